// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
//   Parametrised decode-stage register file with a per-register pending-write
//   scoreboard. The hazard unit uses the scoreboard to see which source
//   registers are still waiting for a producer.
//
//   Ports:
//     clk            rising-edge clock for all state
//     reset          synchronous active-high clear of registers and scoreboard
//     RegWrite       write enable
//     WriteRegister  write index
//     WriteData      write data, stored unmodified
//     ReadRegister1  read port 1 index
//     ReadRegister2  read port 2 index
//     ReadData1      read port 1 data (combinational)
//     ReadData2      read port 2 data (combinational)
//     MarkPending    claim MarkRegister for an issued producer
//     MarkRegister   index being claimed
//     Pending1       ReadRegister1 still awaits its producer
//     Pending2       ReadRegister2 still awaits its producer
//
//   Indices >= DEPTH and the hardwired zero register never hold data or
//   pending state: writes and marks to them are dropped, and reads return zero
//   and not pending.

module regfile_scoreboard #(
  parameter int DATA_WIDTH   = 64,
  parameter int ADDR_WIDTH   = 5,
  parameter int DEPTH        = 32,
  parameter int HAS_ZERO_REG = 1,
  parameter int ZERO_REG     = 31,
  parameter int BYPASS       = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  RegWrite,
  input  logic [ADDR_WIDTH-1:0] WriteRegister,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic [ADDR_WIDTH-1:0] ReadRegister1,
  input  logic [ADDR_WIDTH-1:0] ReadRegister2,
  output logic [DATA_WIDTH-1:0] ReadData1,
  output logic [DATA_WIDTH-1:0] ReadData2,
  input  logic                  MarkPending,
  input  logic [ADDR_WIDTH-1:0] MarkRegister,
  output logic                  Pending1,
  output logic                  Pending2
);

  localparam int                  LP_IDXW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] LP_DEPTH    = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LP_ZERO   = ADDR_WIDTH'(ZERO_REG);
  localparam logic                LP_HAS_ZERO = (HAS_ZERO_REG != 0);
  localparam logic                LP_BYPASS   = (BYPASS != 0);

  // An index is usable when it names an implemented register that is not the
  // hardwired zero register.
  function automatic logic isUsable(input logic [ADDR_WIDTH-1:0] idx);
    return ({1'b0, idx} < LP_DEPTH) && !(LP_HAS_ZERO && (idx == LP_ZERO));
  endfunction

  logic [DATA_WIDTH-1:0] r_regs [DEPTH];
  logic [DEPTH-1:0]      r_pending;

  logic               w_wrUsable;
  logic               w_markUsable;
  logic               w_rd1Usable;
  logic               w_rd2Usable;
  logic               w_bypass1;
  logic               w_bypass2;
  logic [LP_IDXW-1:0] w_wrIdx;
  logic [LP_IDXW-1:0] w_markIdx;
  logic [LP_IDXW-1:0] w_rd1Idx;
  logic [LP_IDXW-1:0] w_rd2Idx;

  assign w_wrUsable   = RegWrite && isUsable(WriteRegister);
  assign w_markUsable = MarkPending && isUsable(MarkRegister);
  assign w_rd1Usable  = isUsable(ReadRegister1);
  assign w_rd2Usable  = isUsable(ReadRegister2);

  // Only used once the index has been qualified as usable, so the dropped
  // upper bits are always zero at that point.
  assign w_wrIdx   = WriteRegister[LP_IDXW-1:0];
  assign w_markIdx = MarkRegister[LP_IDXW-1:0];
  assign w_rd1Idx  = ReadRegister1[LP_IDXW-1:0];
  assign w_rd2Idx  = ReadRegister2[LP_IDXW-1:0];

  // Forwarding deliberately ignores reset: a write presented in the reset
  // cycle is still visible combinationally even though it is never stored.
  // A usable write index that matches the read index implies the read index
  // is usable too.
  assign w_bypass1 = LP_BYPASS && w_wrUsable && (WriteRegister == ReadRegister1);
  assign w_bypass2 = LP_BYPASS && w_wrUsable && (WriteRegister == ReadRegister2);

  // Register storage: reset wipes every implemented register, otherwise a
  // qualified write updates one entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wrUsable) begin
      r_regs[w_wrIdx] <= WriteData;
    end
  end

  // Scoreboard: the mark is assigned after the write-clear so that a mark and
  // a write to the same register leave the bit set (the newly issued producer
  // owns the register).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pending <= '0;
    end else begin
      if (w_wrUsable) begin
        r_pending[w_wrIdx] <= 1'b0;
      end
      if (w_markUsable) begin
        r_pending[w_markIdx] <= 1'b1;
      end
    end
  end

  always_comb begin
    ReadData1 = '0;
    if (w_bypass1) begin
      ReadData1 = WriteData;
    end else if (w_rd1Usable) begin
      ReadData1 = r_regs[w_rd1Idx];
    end
  end

  always_comb begin
    ReadData2 = '0;
    if (w_bypass2) begin
      ReadData2 = WriteData;
    end else if (w_rd2Usable) begin
      ReadData2 = r_regs[w_rd2Idx];
    end
  end

  // A forwarded operand is no longer waiting, so bypass masks the pending bit.
  assign Pending1 = w_rd1Usable && !w_bypass1 && r_pending[w_rd1Idx];
  assign Pending2 = w_rd2Usable && !w_bypass2 && r_pending[w_rd2Idx];

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard
//   Drives three regfile_scoreboard instances from one stimulus stream:
//     dut0: defaults (64-bit, 32 regs, zero reg 31, bypass on)
//     dut1: defaults but bypass off
//     dut2: 32-bit, 16 regs, zero reg 0, bypass on
//   A behavioural register-file model predicts every output each cycle, and
//   hand-computed literal checks pin the model at the interesting points.

module tb_regfile_scoreboard;

  logic        clk;
  logic        reset;
  logic        regWrite;
  logic [4:0]  writeRegister;
  logic [63:0] writeData;
  logic [4:0]  readRegister1;
  logic [4:0]  readRegister2;
  logic        markPending;
  logic [4:0]  markRegister;

  logic [63:0] rdA1, rdA2, rdB1, rdB2;
  logic [31:0] rdC1, rdC2;
  logic        pA1, pA2, pB1, pB2, pC1, pC2;

  int compareCount  = 0;
  int mismatchCount = 0;
  bit checkEn       = 0;

  regfile_scoreboard u_dut0 (
    .clk(clk), .reset(reset), .RegWrite(regWrite),
    .WriteRegister(writeRegister), .WriteData(writeData),
    .ReadRegister1(readRegister1), .ReadRegister2(readRegister2),
    .ReadData1(rdA1), .ReadData2(rdA2),
    .MarkPending(markPending), .MarkRegister(markRegister),
    .Pending1(pA1), .Pending2(pA2)
  );

  regfile_scoreboard #(.BYPASS(0)) u_dut1 (
    .clk(clk), .reset(reset), .RegWrite(regWrite),
    .WriteRegister(writeRegister), .WriteData(writeData),
    .ReadRegister1(readRegister1), .ReadRegister2(readRegister2),
    .ReadData1(rdB1), .ReadData2(rdB2),
    .MarkPending(markPending), .MarkRegister(markRegister),
    .Pending1(pB1), .Pending2(pB2)
  );

  regfile_scoreboard #(.DATA_WIDTH(32), .DEPTH(16), .ZERO_REG(0)) u_dut2 (
    .clk(clk), .reset(reset), .RegWrite(regWrite),
    .WriteRegister(writeRegister), .WriteData(writeData[31:0]),
    .ReadRegister1(readRegister1), .ReadRegister2(readRegister2),
    .ReadData1(rdC1), .ReadData2(rdC2),
    .MarkPending(markPending), .MarkRegister(markRegister),
    .Pending1(pC1), .Pending2(pC2)
  );

  // Per-instance configuration and model state.
  int          cfgDepth  [3] = '{32, 32, 16};
  int          cfgZero   [3] = '{31, 31, 0};
  bit          cfgBypass [3] = '{1'b1, 1'b0, 1'b1};
  logic [63:0] cfgMask   [3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                                 64'h0000_0000_FFFF_FFFF};
  logic [63:0] modelRegs [3][32];
  bit          modelPend [3][32];

  logic [63:0] actRd1 [3];
  logic [63:0] actRd2 [3];
  logic        actP1  [3];
  logic        actP2  [3];

  assign actRd1[0] = rdA1;
  assign actRd1[1] = rdB1;
  assign actRd1[2] = {32'b0, rdC1};
  assign actRd2[0] = rdA2;
  assign actRd2[1] = rdB2;
  assign actRd2[2] = {32'b0, rdC2};
  assign actP1[0]  = pA1;
  assign actP1[1]  = pB1;
  assign actP1[2]  = pC1;
  assign actP2[0]  = pA2;
  assign actP2[1]  = pB2;
  assign actP2[2]  = pC2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit usable(int k, int idx);
    return (idx < cfgDepth[k]) && (idx != cfgZero[k]);
  endfunction

  function automatic bit forwarding(int k, int idx);
    return cfgBypass[k] && regWrite && usable(k, idx) && (int'(writeRegister) == idx);
  endfunction

  function automatic logic [63:0] expData(int k, int idx);
    if (!usable(k, idx)) return 64'b0;
    if (forwarding(k, idx)) return writeData & cfgMask[k];
    return modelRegs[k][idx];
  endfunction

  function automatic logic expPend(int k, int idx);
    if (!usable(k, idx)) return 1'b0;
    if (forwarding(k, idx)) return 1'b0;
    return modelPend[k][idx];
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    compareCount++;
    if (actual !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic wr, input int wa,
                               input logic [63:0] wd, input int ra1, input int ra2,
                               input logic mp, input int ma);
    @(posedge clk);
    #1;
    reset         = rst;
    regWrite      = wr;
    writeRegister = 5'(wa);
    writeData     = wd;
    readRegister1 = 5'(ra1);
    readRegister2 = 5'(ra2);
    markPending   = mp;
    markRegister  = 5'(ma);
  endtask

  // Model state update: reset clears, a usable write stores data and retires
  // the pending bit, then a usable mark claims its register.
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (reset) begin
        for (int r = 0; r < 32; r++) begin
          modelRegs[k][r] = 64'b0;
          modelPend[k][r] = 1'b0;
        end
      end else begin
        if (regWrite && usable(k, int'(writeRegister))) begin
          modelRegs[k][writeRegister] = writeData & cfgMask[k];
          modelPend[k][writeRegister] = 1'b0;
        end
        if (markPending && usable(k, int'(markRegister))) begin
          modelPend[k][markRegister] = 1'b1;
        end
      end
    end
  end

  // Every cycle after the first reset edge, all outputs of all instances are
  // checked against the model mid-cycle.
  always @(negedge clk) begin
    if (checkEn) begin
      for (int k = 0; k < 3; k++) begin
        checkOutput($sformatf("dut%0d.rd1", k), actRd1[k], expData(k, int'(readRegister1)));
        checkOutput($sformatf("dut%0d.rd2", k), actRd2[k], expData(k, int'(readRegister2)));
        checkOutput($sformatf("dut%0d.pend1", k), {63'b0, actP1[k]},
                    {63'b0, expPend(k, int'(readRegister1))});
        checkOutput($sformatf("dut%0d.pend2", k), {63'b0, actP2[k]},
                    {63'b0, expPend(k, int'(readRegister2))});
      end
    end
  end

  initial begin
    #100000;
    mismatchCount++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

  initial begin
    reset         = 1'b1;
    regWrite      = 1'b0;
    writeRegister = '0;
    writeData     = '0;
    readRegister1 = '0;
    readRegister2 = '0;
    markPending   = 1'b0;
    markRegister  = '0;
    @(posedge clk);
    #1;
    checkEn = 1'b1;

    $display("[TB] reset state sweep");
    for (int i = 0; i < 32; i++) begin
      applyStimulus(0, 0, 0, 0, i, 31 - i, 0, 0);
      @(negedge clk);
      checkOutput("lit.resetRd1", rdA1, 64'h0);
      checkOutput("lit.resetPend1", {63'b0, pA1}, 64'h0);
    end

    $display("[TB] write X5, read on both ports");
    applyStimulus(0, 1, 5, 64'h0123_4567_89AB_CDEF, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 5, 5, 0, 0);
    @(negedge clk);
    checkOutput("lit.x5.rd1", rdA1, 64'h0123_4567_89AB_CDEF);
    checkOutput("lit.x5.rd2", rdA2, 64'h0123_4567_89AB_CDEF);
    checkOutput("lit.x5.narrow", {32'b0, rdC1}, 64'h89AB_CDEF);

    $display("[TB] zero register X31 write and mark");
    applyStimulus(0, 1, 31, 64'hFFFF_FFFF_FFFF_FFFF, 31, 31, 1, 31);
    @(negedge clk);
    checkOutput("lit.x31.sameRd", rdA1, 64'h0);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, 0, 0, 0, 31, 31, 0, 0);
      @(negedge clk);
      checkOutput("lit.x31.rd1", rdA1, 64'h0);
      checkOutput("lit.x31.pend1", {63'b0, pA1}, 64'h0);
    end

    $display("[TB] bypass of X7");
    applyStimulus(0, 1, 7, 64'hDEAD_BEEF, 7, 7, 0, 0);
    @(negedge clk);
    checkOutput("lit.x7.bypassRd", rdA1, 64'hDEAD_BEEF);
    checkOutput("lit.x7.bypassPend", {63'b0, pA1}, 64'h0);
    checkOutput("lit.x7.noBypassRd", rdB1, 64'h0);
    applyStimulus(0, 0, 0, 0, 7, 7, 0, 0);
    @(negedge clk);
    checkOutput("lit.x7.noBypassNext", rdB1, 64'hDEAD_BEEF);

    $display("[TB] scoreboard on X3");
    applyStimulus(0, 0, 0, 0, 3, 3, 1, 3);
    @(negedge clk);
    checkOutput("lit.x3.beforeMark", {63'b0, pA1}, 64'h0);
    applyStimulus(0, 0, 0, 0, 3, 3, 0, 0);
    @(negedge clk);
    checkOutput("lit.x3.marked", {63'b0, pA1}, 64'h1);
    applyStimulus(0, 1, 3, 64'h33, 3, 3, 1, 3);
    @(negedge clk);
    checkOutput("lit.x3.markWriteBypass", {63'b0, pA1}, 64'h0);
    checkOutput("lit.x3.markWriteNoBypass", {63'b0, pB1}, 64'h1);
    applyStimulus(0, 0, 0, 0, 3, 3, 0, 0);
    @(negedge clk);
    checkOutput("lit.x3.stillPending", {63'b0, pA1}, 64'h1);
    checkOutput("lit.x3.data", rdB1, 64'h33);
    applyStimulus(0, 1, 3, 64'h44, 3, 3, 0, 0);
    @(negedge clk);
    checkOutput("lit.x3.retireNoBypass", {63'b0, pB1}, 64'h1);
    applyStimulus(0, 0, 0, 0, 3, 3, 0, 0);
    @(negedge clk);
    checkOutput("lit.x3.retired", {63'b0, pA1}, 64'h0);
    checkOutput("lit.x3.retiredB", {63'b0, pB1}, 64'h0);

    $display("[TB] reset mid-operation on X9");
    applyStimulus(0, 1, 9, 64'h55, 9, 5, 1, 9);
    applyStimulus(0, 0, 0, 0, 9, 5, 0, 0);
    @(negedge clk);
    checkOutput("lit.x9.data", rdA1, 64'h55);
    checkOutput("lit.x9.pend", {63'b0, pA1}, 64'h1);
    applyStimulus(1, 1, 9, 64'hAA, 9, 5, 1, 9);
    @(negedge clk);
    checkOutput("lit.x9.bypassDuringReset", rdA1, 64'hAA);
    applyStimulus(0, 0, 0, 0, 9, 5, 0, 0);
    @(negedge clk);
    checkOutput("lit.x9.afterReset", rdA1, 64'h0);
    checkOutput("lit.x9.pendAfterReset", {63'b0, pA1}, 64'h0);
    checkOutput("lit.x5.afterReset", rdA2, 64'h0);

    $display("[TB] out-of-range and zero register on narrow instance");
    applyStimulus(0, 1, 20, 64'h1234, 20, 20, 1, 20);
    @(negedge clk);
    checkOutput("lit.idx20.narrowSame", {32'b0, rdC1}, 64'h0);
    applyStimulus(0, 0, 0, 0, 20, 20, 0, 0);
    @(negedge clk);
    checkOutput("lit.idx20.narrow", {32'b0, rdC1}, 64'h0);
    checkOutput("lit.idx20.narrowPend", {63'b0, pC1}, 64'h0);
    checkOutput("lit.idx20.wide", rdA1, 64'h1234);
    checkOutput("lit.idx20.widePend", {63'b0, pA1}, 64'h1);
    applyStimulus(0, 1, 0, 64'h77, 1, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("lit.x0.narrow", {32'b0, rdC1}, 64'h0);
    checkOutput("lit.x0.wide", rdA1, 64'h77);

    $display("[TB] mark and write to different registers");
    applyStimulus(0, 1, 13, 64'hC0FFEE, 12, 13, 1, 12);
    applyStimulus(0, 0, 0, 0, 12, 13, 0, 0);
    @(negedge clk);
    checkOutput("lit.x12.pend", {63'b0, pA1}, 64'h1);
    checkOutput("lit.x13.pend", {63'b0, pA2}, 64'h0);
    checkOutput("lit.x13.narrow", {32'b0, rdC2}, 64'h00C0_FFEE);

    $display("[TB] directed write/read pattern");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 1, 2 * i + 1, {32'hA5A5_0000 | 32'(i), 32'h1000_0000 + 32'(i)},
                    2 * i + 1, 2 * i, i[0], 2 * i + 2);
    end
    for (int i = 0; i < 16; i++) begin
      applyStimulus(0, 0, 0, 0, i, 31 - i, 0, 0);
    end

    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkEn = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
